// File: rtl/win_checker.sv
// Connect-four style win/draw checker: loads one column into a 7x6 shadow board,
// then scans every cell as the anchor of four 4-cell windows, stopping at the first win.
module win_checker (
  input  logic       clk,
  input  logic       reset,
  input  logic       logic_go,
  input  logic       logic_reset,
  input  logic [2:0] col_addr,
  input  logic [5:0] col_onoff,
  input  logic [5:0] col_player,
  output logic       logic_result,
  output logic       win_player,
  output logic       draw,
  output logic       logic_busy,
  output logic       logic_done
);

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

  // Window directions, bit d per direction: right, up, up-right, down-right.
  localparam logic [3:0] DIR_DC = 4'b1101;
  localparam logic [3:0] DIR_UP = 4'b0110;
  localparam logic [3:0] DIR_DN = 4'b1000;

  state_t          state, state_nxt;
  logic [6:0][5:0] occ, own;
  logic [2:0]      scan_col, scan_row;
  logic            scan_last, found, found_player, board_full;

  assign scan_last  = (scan_col == 3'd6) && (scan_row == 3'd5);
  assign logic_busy = (state == LOAD) || (state == SCAN);
  assign logic_done = (state == DONE);

  always_comb begin
    board_full = 1'b1;
    for (int c = 0; c < 7; c++) board_full = board_full & occ[c][5];
  end

  // All windows anchored at one cell share that cell, so any hit carries its owner.
  always_comb begin : window_scan
    logic [3:0] cc, rr;
    logic       inb, all_occ, all_one, any_one;
    found        = 1'b0;
    found_player = 1'b0;
    cc = '0; rr = '0; inb = 1'b0; all_occ = 1'b0; all_one = 1'b0; any_one = 1'b0;
    for (int d = 0; d < 4; d++) begin
      inb = 1'b1; all_occ = 1'b1; all_one = 1'b1; any_one = 1'b0;
      for (int i = 0; i < 4; i++) begin
        cc = {1'b0, scan_col} + (DIR_DC[d] ? 4'(i) : 4'd0);
        rr = DIR_UP[d] ? {1'b0, scan_row} + 4'(i) :
             DIR_DN[d] ? {1'b0, scan_row} - 4'(i) : {1'b0, scan_row};
        // Row underflow wraps above 5, so one upper-bound test covers both edges.
        if (cc > 4'd6 || rr > 4'd5) inb = 1'b0;
        else begin
          all_occ = all_occ & occ[cc[2:0]][rr[2:0]];
          all_one = all_one & own[cc[2:0]][rr[2:0]];
          any_one = any_one | own[cc[2:0]][rr[2:0]];
        end
      end
      if (inb && all_occ && (all_one || !any_one)) begin
        found        = 1'b1;
        found_player = all_one;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (logic_go) state_nxt = LOAD;
      LOAD:    state_nxt = SCAN;
      SCAN:    if (found || scan_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (logic_reset) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ          <= '0;
      own          <= '0;
      scan_col     <= '0;
      scan_row     <= '0;
      logic_result <= 1'b0;
      win_player   <= 1'b0;
      draw         <= 1'b0;
    end else if (logic_reset) begin
      occ          <= '0;
      own          <= '0;
      scan_col     <= '0;
      scan_row     <= '0;
      logic_result <= 1'b0;
      win_player   <= 1'b0;
      draw         <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (col_addr != 3'd7) begin
            occ[col_addr] <= col_onoff;
            own[col_addr] <= col_player;
          end
          scan_col <= '0;
          scan_row <= '0;
        end
        SCAN: begin
          if (scan_row == 3'd5) begin
            scan_row <= '0;
            scan_col <= scan_col + 3'd1;
          end else begin
            scan_row <= scan_row + 3'd1;
          end
          // Result is sticky: later checks never overwrite it.
          if (!logic_result) begin
            if (found) begin
              logic_result <= 1'b1;
              win_player   <= found_player;
            end else if (scan_last && board_full) begin
              logic_result <= 1'b1;
              draw         <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
